// File: rtl/cmult_pkg.sv
// Shared types and helpers for the complex-multiplier scheduling slice:
// operand/product structs and the requester tag width function.
package cmult_pkg;

  localparam int DW_DEF = 8;

  // A tag must be at least one bit wide, even for a single requester.
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [2*DW_DEF-1:0] re;
    logic signed [2*DW_DEF-1:0] im;
  } cprod_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after 'last' and
// wraps around, and the first set request bit wins.
module rr_arbiter
  import cmult_pkg::*;
#(
  parameter  int N     = 4,
  localparam int TAG_W = tag_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [TAG_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [TAG_W-1:0] idx,
  output logic             found
);

  logic [TAG_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = TAG_W'((int'(last) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/cmult_rr_sched.sv
// Round-robin front end for one shared pipelined complex multiplier; tags ride
// a delay line matched to MULT_LAT. Optional macro CMULT_RR_SCHED_CHECK_EN adds
// an alignment checker (mult_valid_i in, sticky err_o out).
module cmult_rr_sched
  import cmult_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int DW       = DW_DEF,
  parameter  int MULT_LAT = 2,
  localparam int TAG_W    = tag_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*DW-1:0]    op_re1_i,
  input  logic [N_REQ*DW-1:0]    op_im1_i,
  input  logic [N_REQ*DW-1:0]    op_re2_i,
  input  logic [N_REQ*DW-1:0]    op_im2_i,
  output logic [N_REQ-1:0]       ack_o,
  output logic signed [DW-1:0]   mult_re1_o,
  output logic signed [DW-1:0]   mult_im1_o,
  output logic signed [DW-1:0]   mult_re2_o,
  output logic signed [DW-1:0]   mult_im2_o,
  output logic                   mult_valid_o,
  input  logic signed [2*DW-1:0] mult_re_i,
  input  logic signed [2*DW-1:0] mult_im_i,
  output logic                   res_valid_o,
  output logic [TAG_W-1:0]       res_tag_o,
  output logic signed [2*DW-1:0] res_re_o,
  output logic signed [2*DW-1:0] res_im_o,
  output logic                   busy_o
`ifdef CMULT_RR_SCHED_CHECK_EN
  ,
  input  logic                   mult_valid_i,
  output logic                   err_o
`endif
);

  logic [N_REQ-1:0]    req_masked;
  logic [N_REQ-1:0]    grant;
  logic [TAG_W-1:0]    grant_idx;
  logic                grant_found;
  logic [TAG_W-1:0]    last;
  logic [TAG_W-1:0]    issue_tag;
  logic [MULT_LAT-1:0] dl_valid;
  logic [TAG_W-1:0]    dl_tag [MULT_LAT];

  // A request still high in the cycle after its ack must not be granted twice.
  assign req_masked = req_i & ~ack_o;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_masked),
    .last  (last),
    .grant (grant),
    .idx   (grant_idx),
    .found (grant_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_o        <= '0;
      mult_valid_o <= 1'b0;
      mult_re1_o   <= '0;
      mult_im1_o   <= '0;
      mult_re2_o   <= '0;
      mult_im2_o   <= '0;
      issue_tag    <= '0;
      last         <= TAG_W'(N_REQ - 1);
    end else begin
      ack_o        <= grant;
      mult_valid_o <= grant_found;
      if (grant_found) begin
        mult_re1_o <= op_re1_i[int'(grant_idx)*DW +: DW];
        mult_im1_o <= op_im1_i[int'(grant_idx)*DW +: DW];
        mult_re2_o <= op_re2_i[int'(grant_idx)*DW +: DW];
        mult_im2_o <= op_im2_i[int'(grant_idx)*DW +: DW];
        issue_tag  <= grant_idx;
        last       <= grant_idx;
      end
    end
  end

  // issue_tag travels with mult_valid_o; stage MULT_LAT-1 then lines up with
  // the cycle the multiplier presents the matching product.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_valid <= '0;
      for (int i = 0; i < MULT_LAT; i++) dl_tag[i] <= '0;
    end else begin
      dl_valid[0] <= mult_valid_o;
      dl_tag[0]   <= issue_tag;
      for (int i = 1; i < MULT_LAT; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_tag[i]   <= dl_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_o <= 1'b0;
      res_tag_o   <= '0;
      res_re_o    <= '0;
      res_im_o    <= '0;
    end else begin
      res_valid_o <= dl_valid[MULT_LAT-1];
      if (dl_valid[MULT_LAT-1]) begin
        res_tag_o <= dl_tag[MULT_LAT-1];
        res_re_o  <= mult_re_i;
        res_im_o  <= mult_im_i;
      end
    end
  end

  assign busy_o = (|dl_valid) | mult_valid_o;

`ifdef CMULT_RR_SCHED_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (mult_valid_i != dl_valid[MULT_LAT-1]) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cmult_rr_sched.sv
// Directed bench for cmult_rr_sched with a behavioural MULT_LAT-stage complex
// multiplier; expected products are hand-computed squares of small operands.
module tb_cmult_rr_sched;
  import cmult_pkg::*;

  localparam int N_REQ    = 4;
  localparam int DW       = 8;
  localparam int MULT_LAT = 2;
  localparam int TAG_W    = 2;

  typedef struct {
    int tag;
    int re;
    int im;
    int cyc;
  } res_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ*DW-1:0]    op_re1, op_im1, op_re2, op_im2;
  logic [N_REQ-1:0]       ack_o;
  logic signed [DW-1:0]   mult_re1_o, mult_im1_o, mult_re2_o, mult_im2_o;
  logic                   mult_valid_o;
  logic signed [2*DW-1:0] mult_re, mult_im;
  logic                   res_valid_o;
  logic [TAG_W-1:0]       res_tag_o;
  logic signed [2*DW-1:0] res_re_o, res_im_o;
  logic                   busy_o;
  logic                   force_early = 1'b0;
  logic                   mult_valid_tb;
  logic                   err_o;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  res_t res_q[$];
  int   ack_q[$];
  int   ack_cyc_q[$];
  int   exp_q[$];

  cplx_t op_tab [N_REQ];
  int    exp_re [N_REQ] = '{8, 3, 0, -3};
  int    exp_im [N_REQ] = '{6, 4, 2, 4};

  always #5 clk = ~clk;

  // Behavioural shared multiplier: MULT_LAT register stages, valid resets with rst.
  logic signed [2*DW-1:0] pipe_re [MULT_LAT];
  logic signed [2*DW-1:0] pipe_im [MULT_LAT];
  logic [MULT_LAT-1:0]    pipe_v;
  logic signed [2*DW-1:0] a_re, a_im, b_re, b_im;

  assign a_re = (2*DW)'(mult_re1_o);
  assign a_im = (2*DW)'(mult_im1_o);
  assign b_re = (2*DW)'(mult_re2_o);
  assign b_im = (2*DW)'(mult_im2_o);

  always @(posedge clk) begin
    if (rst) pipe_v <= '0;
    else begin
      pipe_v[0] <= mult_valid_o;
      for (int i = 1; i < MULT_LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
    pipe_re[0] <= a_re * b_re - a_im * b_im;
    pipe_im[0] <= a_re * b_im + a_im * b_re;
    for (int i = 1; i < MULT_LAT; i++) begin
      pipe_re[i] <= pipe_re[i-1];
      pipe_im[i] <= pipe_im[i-1];
    end
  end

  assign mult_re       = pipe_re[MULT_LAT-1];
  assign mult_im       = pipe_im[MULT_LAT-1];
  assign mult_valid_tb = pipe_v[MULT_LAT-1] | force_early;

`ifndef CMULT_RR_SCHED_CHECK_EN
  assign err_o = 1'b0;
`endif

  cmult_rr_sched #(.N_REQ(N_REQ), .DW(DW), .MULT_LAT(MULT_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .op_re1_i     (op_re1),
    .op_im1_i     (op_im1),
    .op_re2_i     (op_re2),
    .op_im2_i     (op_im2),
    .ack_o        (ack_o),
    .mult_re1_o   (mult_re1_o),
    .mult_im1_o   (mult_im1_o),
    .mult_re2_o   (mult_re2_o),
    .mult_im2_o   (mult_im2_o),
    .mult_valid_o (mult_valid_o),
    .mult_re_i    (mult_re),
    .mult_im_i    (mult_im),
    .res_valid_o  (res_valid_o),
    .res_tag_o    (res_tag_o),
    .res_re_o     (res_re_o),
    .res_im_o     (res_im_o),
    .busy_o       (busy_o)
`ifdef CMULT_RR_SCHED_CHECK_EN
    ,
    .mult_valid_i (mult_valid_tb),
    .err_o        (err_o)
`endif
  );

  always @(negedge clk) begin
    cycle++;
    if (!rst && res_valid_o)
      res_q.push_back('{tag: int'(res_tag_o), re: int'(res_re_o), im: int'(res_im_o), cyc: cycle});
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int onehotIdx(input logic [N_REQ-1:0] v);
    int r = -1;
    for (int i = 0; i < N_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic clearLogs();
    res_q.delete();
    ack_q.delete();
    ack_cyc_q.delete();
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Raise the pattern; each requester drops its bit once it sees its ack.
  task automatic applyStimulus(input logic [N_REQ-1:0] pattern, input int max_cyc);
    int n = 0;
    req = pattern;
    while (req != '0 && n < max_cyc) begin
      tick();
      n++;
      if (ack_o != '0) begin
        ack_q.push_back(onehotIdx(ack_o));
        ack_cyc_q.push_back(cycle);
        req = req & ~ack_o;
      end
    end
    if (req != '0) begin
      checkOutput("ack_timeout", int'(req), 0);
      req = '0;
    end
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((busy_o || res_valid_o) && n < max_cyc) begin
      tick();
      n++;
    end
    if (busy_o || res_valid_o) checkOutput("drain_timeout", int'(busy_o), 0);
  endtask

  task automatic checkRun(input string name);
    checkOutput({name, "_ack_count"}, ack_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ack_q.size(); i++)
      checkOutput({name, "_ack_idx"}, ack_q[i], exp_q[i]);
    checkOutput({name, "_res_count"}, res_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < res_q.size(); i++) begin
      checkOutput({name, "_res_tag"}, res_q[i].tag, exp_q[i]);
      checkOutput({name, "_res_re"}, res_q[i].re, exp_re[exp_q[i]]);
      checkOutput({name, "_res_im"}, res_q[i].im, exp_im[exp_q[i]]);
    end
  endtask

  initial begin
    op_tab[0] = '{re: 8'sd3, im: 8'sd1};
    op_tab[1] = '{re: 8'sd2, im: 8'sd1};
    op_tab[2] = '{re: 8'sd1, im: 8'sd1};
    op_tab[3] = '{re: 8'sd1, im: 8'sd2};
    for (int k = 0; k < N_REQ; k++) begin
      op_re1[k*DW +: DW] = op_tab[k].re;
      op_im1[k*DW +: DW] = op_tab[k].im;
      op_re2[k*DW +: DW] = op_tab[k].re;
      op_im2[k*DW +: DW] = op_tab[k].im;
    end

    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_ack", int'(ack_o), 0);
    checkOutput("rst_mult_valid", int'(mult_valid_o), 0);
    checkOutput("rst_mult_re1", int'(mult_re1_o), 0);
    checkOutput("rst_res_valid", int'(res_valid_o), 0);
    checkOutput("rst_res_tag", int'(res_tag_o), 0);
    checkOutput("rst_res_re", int'(res_re_o), 0);
    checkOutput("rst_res_im", int'(res_im_o), 0);
    checkOutput("rst_busy", int'(busy_o), 0);
    rst = 1'b0;

    // Single request, exact latency and single-pulse result.
    req = 4'b0001;
    tick();
    checkOutput("s1_ack", int'(ack_o), 1);
    checkOutput("s1_mult_valid", int'(mult_valid_o), 1);
    checkOutput("s1_mult_re1", int'(mult_re1_o), 3);
    checkOutput("s1_mult_im2", int'(mult_im2_o), 1);
    checkOutput("s1_busy", int'(busy_o), 1);
    req = '0;
    for (int i = 1; i <= MULT_LAT; i++) begin
      tick();
      checkOutput("s1_ack_low", int'(ack_o), 0);
      checkOutput("s1_early_valid", int'(res_valid_o), 0);
    end
    tick();
    checkOutput("s1_res_valid", int'(res_valid_o), 1);
    checkOutput("s1_res_tag", int'(res_tag_o), 0);
    checkOutput("s1_res_re", int'(res_re_o), 8);
    checkOutput("s1_res_im", int'(res_im_o), 6);
    tick();
    checkOutput("s1_single_pulse", int'(res_valid_o), 0);
    checkOutput("s1_hold_re", int'(res_re_o), 8);

    // All four requesters at once after a fresh reset.
    doReset();
    clearLogs();
    exp_q = '{0, 1, 2, 3};
    applyStimulus(4'b1111, 20);
    drain(30);
    checkRun("s2");
    for (int i = 1; i < 4 && i < ack_cyc_q.size(); i++)
      checkOutput("s2_ack_consecutive", ack_cyc_q[i] - ack_cyc_q[0], i);
    for (int i = 1; i < 4 && i < res_q.size(); i++)
      checkOutput("s2_res_back_to_back", res_q[i].cyc - res_q[0].cyc, i);

    // Wrap-around: 3, then 1001 gives 0 before 3.
    clearLogs();
    exp_q = '{3, 0, 3};
    applyStimulus(4'b1000, 20);
    applyStimulus(4'b1001, 20);
    drain(30);
    checkRun("s3");

    // Requester 2 held high: ack masking gives alternate-cycle grants.
    clearLogs();
    req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("s4_ack_alt", int'(ack_o), (i % 2 == 0) ? 4 : 0);
      if (ack_o != '0) ack_q.push_back(onehotIdx(ack_o));
    end
    req = '0;
    drain(30);
    exp_q = '{2, 2, 2};
    checkRun("s4");

    // Reset mid-flight after two issues (3 then 0, leaving the pointer at 0).
    clearLogs();
    applyStimulus(4'b1001, 20);
    checkOutput("s5_pre_acks", ack_q.size(), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("s5_busy_after_rst", int'(busy_o), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("s5_no_result", int'(res_valid_o), 0);
    end
    checkOutput("s5_busy_idle", int'(busy_o), 0);
    checkOutput("s5_res_count", res_q.size(), 0);
    clearLogs();
    exp_q = '{0, 1};
    applyStimulus(4'b0011, 20);
    drain(30);
    checkRun("s5_post");

`ifdef CMULT_RR_SCHED_CHECK_EN
    checkOutput("s6_err_clean", int'(err_o), 0);
    clearLogs();
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    force_early = 1'b1;
    tick();
    force_early = 1'b0;
    checkOutput("s6_err_set", int'(err_o), 1);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("s6_err_sticky", int'(err_o), 1);
    doReset();
    checkOutput("s6_err_cleared", int'(err_o), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
